// File: rtl/request_unpacker_pkg.sv
// Shared definitions for the PC-link request unpacker and response packer:
// data-type encodings, request codes, unpacker states and the decode record.
package request_unpacker_pkg;

  typedef enum logic [1:0] {
    DT_N = 2'b00,
    DT_T = 2'b01,
    DT_H = 2'b10,
    DT_S = 2'b11
  } data_type_e;

  localparam logic [7:0] REQ_SINGLE_S = 8'h00;
  localparam logic [7:0] REQ_SINGLE_T = 8'h01;
  localparam logic [7:0] REQ_SINGLE_H = 8'h02;
  localparam logic [7:0] REQ_CONT_T   = 8'h03;
  localparam logic [7:0] REQ_CONT_H   = 8'h04;
  localparam logic [7:0] REQ_BREAK_T  = 8'h05;
  localparam logic [7:0] REQ_BREAK_H  = 8'h06;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ADDR,
    ST_PENDING
  } state_e;

  typedef struct packed {
    data_type_e data_type;
    logic       continuous;
    logic       break_continuous;
    logic       err_cmd;
  } cmd_decode_t;

endpackage

// File: rtl/request_unpacker_cmd_decoder.sv
// Combinational command-byte decoder: byte -> data type, continuous-mode
// controls and unknown-command flag.
module request_unpacker_cmd_decoder
  import request_unpacker_pkg::*;
(
  input  logic [7:0]  cmd_byte,
  output cmd_decode_t decoded
);

  always_comb begin
    decoded = '0;
    unique case (cmd_byte)
      REQ_SINGLE_S: decoded.data_type = DT_S;
      REQ_SINGLE_T: decoded.data_type = DT_T;
      REQ_SINGLE_H: decoded.data_type = DT_H;
      REQ_CONT_T: begin
        decoded.data_type  = DT_T;
        decoded.continuous = 1'b1;
      end
      REQ_CONT_H: begin
        decoded.data_type  = DT_H;
        decoded.continuous = 1'b1;
      end
      REQ_BREAK_T: begin
        decoded.data_type        = DT_T;
        decoded.break_continuous = 1'b1;
      end
      REQ_BREAK_H: begin
        decoded.data_type        = DT_H;
        decoded.break_continuous = 1'b1;
      end
      default: decoded.err_cmd = 1'b1;
    endcase
  end

endmodule

// File: rtl/request_unpacker.sv
// Assembles 2-byte PC-link requests (command, address), decodes them and holds
// them until accepted. Define UNPACKER_TIMEOUT_EN to abandon a stalled request.
module request_unpacker
  import request_unpacker_pkg::*;
#(
  parameter int unsigned NUM_SENSORS    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RX_VALID,
  input  logic [7:0] RX_BYTE,
  input  logic       CMD_READY,
  output logic       CMD_VALID,
  output logic [1:0] DATA_TYPE,
  output logic       CONTINUOUS,
  output logic       BREAK_CONTINUOUS,
  output logic [7:0] ADDRESS,
  output logic       ERR_CMD,
  output logic       ERR_ADDR
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        cmd_valid_q, cmd_valid_d;
  cmd_decode_t dec_q, dec_d;
  logic [7:0]  address_q, address_d;
  logic        err_addr_q, err_addr_d;
  cmd_decode_t dec_now;

  request_unpacker_cmd_decoder u_cmd_decoder (
    .cmd_byte (cmd_q),
    .decoded  (dec_now)
  );

`ifdef UNPACKER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;
  // cnt_q counts completed WAIT_ADDR cycles, so this fires in cycle TIMEOUT_CYCLES
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    dec_d       = dec_q;
    address_d   = address_q;
    err_addr_d  = err_addr_q;
`ifdef UNPACKER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (RX_VALID) begin
          cmd_d   = RX_BYTE;
          state_d = ST_WAIT_ADDR;
`ifdef UNPACKER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_WAIT_ADDR: begin
        if (RX_VALID) begin
          dec_d       = dec_now;
          address_d   = RX_BYTE;
          err_addr_d  = (32'(RX_BYTE) >= NUM_SENSORS);
          cmd_valid_d = 1'b1;
          state_d     = ST_PENDING;
        end
`ifdef UNPACKER_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_PENDING: begin
        // Bytes arriving here, including in the accept cycle, are dropped
        if (CMD_READY) begin
          cmd_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      dec_q       <= '0;
      address_q   <= '0;
      err_addr_q  <= 1'b0;
`ifdef UNPACKER_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      dec_q       <= dec_d;
      address_q   <= address_d;
      err_addr_q  <= err_addr_d;
`ifdef UNPACKER_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign CMD_VALID        = cmd_valid_q;
  assign DATA_TYPE        = dec_q.data_type;
  assign CONTINUOUS       = dec_q.continuous;
  assign BREAK_CONTINUOUS = dec_q.break_continuous;
  assign ADDRESS          = address_q;
  assign ERR_CMD          = dec_q.err_cmd;
  assign ERR_ADDR         = err_addr_q;

endmodule

// File: tb/tb_request_unpacker.sv
// Directed scoreboard bench for request_unpacker; timeout cases are built
// only when UNPACKER_TIMEOUT_EN is defined.
module tb_request_unpacker;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       RX_VALID;
  logic [7:0] RX_BYTE;
  logic       CMD_READY;
  logic       CMD_VALID;
  logic [1:0] DATA_TYPE;
  logic       CONTINUOUS;
  logic       BREAK_CONTINUOUS;
  logic [7:0] ADDRESS;
  logic       ERR_CMD;
  logic       ERR_ADDR;

  typedef struct packed {
    logic [1:0] dt;
    logic       cont;
    logic       brk;
    logic [7:0] addr;
    logic       ecmd;
    logic       eaddr;
  } exp_t;

  exp_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  request_unpacker #(
    .NUM_SENSORS    (32),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .RX_VALID         (RX_VALID),
    .RX_BYTE          (RX_BYTE),
    .CMD_READY        (CMD_READY),
    .CMD_VALID        (CMD_VALID),
    .DATA_TYPE        (DATA_TYPE),
    .CONTINUOUS       (CONTINUOUS),
    .BREAK_CONTINUOUS (BREAK_CONTINUOUS),
    .ADDRESS          (ADDRESS),
    .ERR_CMD          (ERR_CMD),
    .ERR_ADDR         (ERR_ADDR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_VALID = 1'b1;
    RX_BYTE  = b;
    tick();
    RX_VALID = 1'b0;
    RX_BYTE  = '0;
  endtask

  task automatic push_exp(input logic [1:0] dt, input logic cont, input logic brk,
                          input logic [7:0] addr, input logic ecmd, input logic eaddr);
    exp_t e;
    e.dt = dt; e.cont = cont; e.brk = brk; e.addr = addr; e.ecmd = ecmd; e.eaddr = eaddr;
    sb.push_back(e);
  endtask

  task automatic expect_req(input string tag);
    exp_t e;
    int unsigned waited = 0;
    while (CMD_VALID !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_valid"}, 8'(CMD_VALID), 8'h01);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 8'h01, 8'h00);
    end else begin
      e = sb.pop_front();
      check({tag, "_dt"},    8'(DATA_TYPE),        8'(e.dt));
      check({tag, "_cont"},  8'(CONTINUOUS),       8'(e.cont));
      check({tag, "_brk"},   8'(BREAK_CONTINUOUS), 8'(e.brk));
      check({tag, "_addr"},  ADDRESS,              e.addr);
      check({tag, "_ecmd"},  8'(ERR_CMD),          8'(e.ecmd));
      check({tag, "_eaddr"}, 8'(ERR_ADDR),         8'(e.eaddr));
    end
  endtask

  task automatic accept(input string tag);
    CMD_READY = 1'b1;
    tick();
    CMD_READY = 1'b0;
    check({tag, "_drop"}, 8'(CMD_VALID), 8'h00);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 8'(CMD_VALID), 8'h00);
    check({tag, "_dt"},    8'(DATA_TYPE), 8'h00);
    check({tag, "_flags"}, 8'({CONTINUOUS, BREAK_CONTINUOUS, ERR_CMD, ERR_ADDR}), 8'h00);
    check({tag, "_addr"},  ADDRESS, 8'h00);
  endtask

  initial begin
    RST_N = 1'b0; RX_VALID = 1'b0; RX_BYTE = '0; CMD_READY = 1'b0;
    tick(); tick();
    check_idle_outputs("reset");
    RST_N = 1'b1;
    tick();

    // T single read, address 5, held while not ready
    send_byte(8'h01);
    check("t1_no_early_valid", 8'(CMD_VALID), 8'h00);
    push_exp(2'b01, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0);
    send_byte(8'h05);
    check("t1_latency", 8'(CMD_VALID), 8'h01);
    expect_req("t1");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t1_hold_valid", 8'(CMD_VALID), 8'h01);
      check("t1_hold_addr", ADDRESS, 8'h05);
    end
    accept("t1");
    check("t1_dt_kept", 8'(DATA_TYPE), 8'h01);

    // Continuous H, then break H, last valid address
    push_exp(2'b10, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b0);
    send_byte(8'h04); send_byte(8'h1F);
    expect_req("cont_h");
    accept("cont_h");
    push_exp(2'b10, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0);
    send_byte(8'h06); send_byte(8'h1F);
    expect_req("brk_h");
    accept("brk_h");

    // Bad command and first bad address together
    push_exp(2'b00, 1'b0, 1'b0, 8'h20, 1'b1, 1'b1);
    send_byte(8'h09); send_byte(8'h20);
    expect_req("bad");

    // Byte while pending is dropped; byte in the accept cycle is dropped too
    send_byte(8'h02);
    check("pend_drop_valid", 8'(CMD_VALID), 8'h01);
    check("pend_drop_addr", ADDRESS, 8'h20);
    CMD_READY = 1'b1;
    send_byte(8'h03);
    CMD_READY = 1'b0;
    check("accept_rx_drop", 8'(CMD_VALID), 8'h00);
    check("accept_err_kept", 8'(ERR_CMD), 8'h01);

    // Ready while nothing pending is ignored
    CMD_READY = 1'b1;
    tick(); tick();
    CMD_READY = 1'b0;
    check("idle_ready", 8'(CMD_VALID), 8'h00);

    push_exp(2'b11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte(8'h00); send_byte(8'h00);
    expect_req("s_after_drop");
    accept("s_after_drop");

    // RX_VALID held high over two cycles gives two bytes
    push_exp(2'b01, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0);
    RX_VALID = 1'b1; RX_BYTE = 8'h03;
    tick();
    RX_BYTE = 8'h07;
    tick();
    RX_VALID = 1'b0; RX_BYTE = '0;
    check("b2b_latency", 8'(CMD_VALID), 8'h01);
    expect_req("b2b");
    accept("b2b");

    // Reset between bytes discards the partial request (asynchronously)
    send_byte(8'h01);
    #2 RST_N = 1'b0;
    #1 check_idle_outputs("rst_mid_async");
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_mid_no_valid", 8'(CMD_VALID), 8'h00);
    end
    push_exp(2'b10, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);
    send_byte(8'h02); send_byte(8'h01);
    expect_req("h_after_rst");

    // Reset while pending drops the request
    RST_N = 1'b0;
    tick();
    check_idle_outputs("rst_pend");
    RST_N = 1'b1;
    tick(); tick();
    check("rst_pend_no_valid", 8'(CMD_VALID), 8'h00);

    // Valid command with address 0xFF
    push_exp(2'b11, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
    send_byte(8'h00); send_byte(8'hFF);
    expect_req("addr_ff");
    accept("addr_ff");

`ifdef UNPACKER_TIMEOUT_EN
    // Stalled command byte is abandoned after 100 idle cycles
    send_byte(8'h01);
    for (int i = 0; i < 100; i++) tick();
    check("to_no_valid", 8'(CMD_VALID), 8'h00);
    push_exp(2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte(8'h03); send_byte(8'h00);
    expect_req("to_expired");
    accept("to_expired");

    // Address byte in cycle 100 wins over the timeout
    send_byte(8'h01);
    for (int i = 0; i < 99; i++) tick();
    push_exp(2'b01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
    send_byte(8'h02);
    check("to_edge_latency", 8'(CMD_VALID), 8'h01);
    expect_req("to_edge");
    accept("to_edge");
`endif

    check("sb_drained", 8'(sb.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
